// File: rtl/pc_seq_pkg.sv
// Shared definitions for the PC sequencing controller: FSM state codes,
// next-address source selector and default vector addresses.
package pc_seq_pkg;

  localparam int          ADDR_W_DEF   = 30;
  localparam logic [29:0] RESET_PC_DEF = 30'hbff;
  localparam logic [29:0] EXC_VEC_DEF  = 30'h0020;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_UPDATE = 3'd4;
  localparam logic [2:0] ST_TRAP   = 3'd5;

  typedef enum logic [2:0] {
    NPC_SEQ  = 3'd0,
    NPC_BR   = 3'd1,
    NPC_J    = 3'd2,
    NPC_JR   = 3'd3,
    NPC_ERET = 3'd4,
    NPC_VEC  = 3'd5
  } npc_src_e;

endpackage

// File: rtl/pc_seq_ctrl_npc_calc.sv
// Combinational next-word-address mux: sequential, branch, jump, jr, eret
// and vector targets, selected by the npc source code. All sums wrap modulo 2^ADDR_W.
module npc_calc
  import pc_seq_pkg::*;
#(
  parameter int                ADDR_W  = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] EXC_VEC = EXC_VEC_DEF
) (
  input  logic [2:0]        src_i,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic [15:0]       imm16_i,
  input  logic [25:0]       jidx_i,
  input  logic [31:0]       rs_val_i,
  input  logic [ADDR_W-1:0] epc_i,
  output logic [ADDR_W-1:0] npc_o
);

  logic [ADDR_W-1:0] pc1_s;
  logic [ADDR_W-1:0] br_s;
  logic [ADDR_W-1:0] j_s;

  assign pc1_s = pc_i + {{(ADDR_W-1){1'b0}}, 1'b1};
  assign br_s  = pc1_s + {{(ADDR_W-16){imm16_i[15]}}, imm16_i};
  // Jump keeps the top region bits of the incremented PC.
  assign j_s   = {pc1_s[ADDR_W-1:26], jidx_i};

  // Target select
  always_comb begin
    npc_o = pc1_s;
    case (src_i)
      NPC_SEQ:  npc_o = pc1_s;
      NPC_BR:   npc_o = br_s;
      NPC_J:    npc_o = j_s;
      NPC_JR:   npc_o = rs_val_i[ADDR_W+1:2];
      NPC_ERET: npc_o = epc_i;
      NPC_VEC:  npc_o = EXC_VEC;
      default:  npc_o = pc1_s;
    endcase
  end

endmodule

// File: rtl/pc_seq_ctrl.sv
// Fetch/decode/execute/update sequencer driving the PC register, with
// exception/interrupt hand-off to EPC. Strobes are decoded from the state register.
module pc_seq_ctrl
  import pc_seq_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF,
  parameter logic [ADDR_W-1:0] EXC_VEC  = EXC_VEC_DEF
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              os_i,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              imem_ack_i,
  input  logic [15:0]       imm16_i,
  input  logic [25:0]       jidx_i,
  input  logic [31:0]       rs_val_i,
  input  logic              is_br_i,
  input  logic              br_taken_i,
  input  logic              is_j_i,
  input  logic              is_jr_i,
  input  logic              is_eret_i,
  input  logic [ADDR_W-1:0] epc_i,
  input  logic              exec_done_i,
  input  logic              exc_req_i,
  input  logic              int_req_i,
  input  logic              int_en_i,
  output logic              imem_req_o,
  output logic              ir_wr_o,
  output logic [ADDR_W-1:0] next_pc_o,
  output logic              pc_wr_o,
  output logic              pc_en_o,
  output logic              epc_wr_o,
  output logic [ADDR_W-1:0] epc_val_o,
  output logic              addr_err_o,
  output logic [2:0]        state_o
);

  logic [2:0]        state_q;
  logic [2:0]        state_d;
  logic [2:0]        flow_src_s;
  logic [2:0]        src_s;
  logic [ADDR_W-1:0] npc_s;
  logic              jr_bad_s;
  logic              int_take_s;

  assign jr_bad_s   = is_jr_i & (rs_val_i[1:0] != 2'b00);
  assign int_take_s = int_req_i & int_en_i;

  // Normal-flow target source, highest priority first
  always_comb begin
    flow_src_s = NPC_SEQ;
    if (is_eret_i) begin
      flow_src_s = NPC_ERET;
    end else if (is_jr_i) begin
      flow_src_s = NPC_JR;
    end else if (is_j_i) begin
      flow_src_s = NPC_J;
    end else if (is_br_i & br_taken_i) begin
      flow_src_s = NPC_BR;
    end else begin
      flow_src_s = NPC_SEQ;
    end
  end

  assign src_s = (state_q == ST_TRAP) ? NPC_VEC : flow_src_s;

  npc_calc #(
    .ADDR_W  (ADDR_W),
    .EXC_VEC (EXC_VEC)
  ) u_npc_calc (
    .src_i    (src_s),
    .pc_i     (pc_i),
    .imm16_i  (imm16_i),
    .jidx_i   (jidx_i),
    .rs_val_i (rs_val_i),
    .epc_i    (epc_i),
    .npc_o    (npc_s)
  );

  // Next-state logic; os low overrides every state
  always_comb begin
    state_d = state_q;
    if (!os_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:   state_d = ST_FETCH;
        ST_FETCH:  state_d = imem_ack_i ? ST_DECODE : ST_FETCH;
        ST_DECODE: state_d = exc_req_i ? ST_TRAP : ST_EXEC;
        ST_EXEC: begin
          if (exc_req_i) begin
            state_d = ST_TRAP;
          end else if (exec_done_i) begin
            state_d = jr_bad_s ? ST_TRAP : ST_UPDATE;
          end else begin
            state_d = ST_EXEC;
          end
        end
        ST_UPDATE: state_d = ST_FETCH;
        ST_TRAP:   state_d = ST_FETCH;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Output decode from the registered state
  always_comb begin
    imem_req_o = 1'b0;
    ir_wr_o    = 1'b0;
    pc_wr_o    = 1'b0;
    epc_wr_o   = 1'b0;
    epc_val_o  = {ADDR_W{1'b0}};
    addr_err_o = 1'b0;
    next_pc_o  = npc_s;
    case (state_q)
      ST_IDLE: next_pc_o = RESET_PC;
      ST_FETCH: begin
        imem_req_o = 1'b1;
        ir_wr_o    = imem_ack_i;
      end
      ST_DECODE: next_pc_o = npc_s;
      ST_EXEC:   addr_err_o = exec_done_i & ~exc_req_i & jr_bad_s;
      ST_UPDATE: begin
        pc_wr_o = 1'b1;
        if (int_take_s) begin
          // Save the address this instruction would have continued to.
          next_pc_o = EXC_VEC;
          epc_wr_o  = 1'b1;
          epc_val_o = npc_s;
        end else begin
          next_pc_o = npc_s;
        end
      end
      ST_TRAP: begin
        pc_wr_o   = 1'b1;
        next_pc_o = EXC_VEC;
        epc_wr_o  = 1'b1;
        epc_val_o = pc_i;
      end
      default: next_pc_o = RESET_PC;
    endcase
  end

  assign pc_en_o = pc_wr_o;
  assign state_o = state_q;

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Directed bench for pc_seq_ctrl: walks the FSM through each next-PC source,
// traps, interrupts, os drop and asynchronous reset with hand-computed expectations.
module tb_pc_seq_ctrl;

  logic        clk_i = 1'b0;
  logic        reset_i, os_i, imem_ack_i;
  logic [29:0] pc_i, epc_i;
  logic [15:0] imm16_i;
  logic [25:0] jidx_i;
  logic [31:0] rs_val_i;
  logic        is_br_i, br_taken_i, is_j_i, is_jr_i, is_eret_i;
  logic        exec_done_i, exc_req_i, int_req_i, int_en_i;
  logic        imem_req_o, ir_wr_o, pc_wr_o, pc_en_o, epc_wr_o, addr_err_o;
  logic [29:0] next_pc_o, epc_val_o;
  logic [2:0]  state_o;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  pc_seq_ctrl dut (
    .clk_i(clk_i), .reset_i(reset_i), .os_i(os_i), .pc_i(pc_i),
    .imem_ack_i(imem_ack_i), .imm16_i(imm16_i), .jidx_i(jidx_i),
    .rs_val_i(rs_val_i), .is_br_i(is_br_i), .br_taken_i(br_taken_i),
    .is_j_i(is_j_i), .is_jr_i(is_jr_i), .is_eret_i(is_eret_i),
    .epc_i(epc_i), .exec_done_i(exec_done_i), .exc_req_i(exc_req_i),
    .int_req_i(int_req_i), .int_en_i(int_en_i),
    .imem_req_o(imem_req_o), .ir_wr_o(ir_wr_o), .next_pc_o(next_pc_o),
    .pc_wr_o(pc_wr_o), .pc_en_o(pc_en_o), .epc_wr_o(epc_wr_o),
    .epc_val_o(epc_val_o), .addr_err_o(addr_err_o), .state_o(state_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  // From FETCH: ack at once, pass DECODE, land in EXEC.
  task automatic fetch_to_exec;
    imem_ack_i = 1'b1;
    #1;
    tick();
    imem_ack_i = 1'b0;
    tick();
  endtask

  // From FETCH: run to the cycle after exec_done (UPDATE or TRAP).
  task automatic run_to_update;
    fetch_to_exec();
    exec_done_i = 1'b1;
    #1;
    tick();
    exec_done_i = 1'b0;
    #1;
  endtask

  initial begin
    reset_i = 1'b0; os_i = 1'b0; imem_ack_i = 1'b0;
    pc_i = 30'h0; epc_i = 30'h0; imm16_i = 16'h0; jidx_i = 26'h0; rs_val_i = 32'h0;
    is_br_i = 1'b0; br_taken_i = 1'b0; is_j_i = 1'b0; is_jr_i = 1'b0; is_eret_i = 1'b0;
    exec_done_i = 1'b0; exc_req_i = 1'b0; int_req_i = 1'b0; int_en_i = 1'b0;

    repeat (2) @(posedge clk_i);
    #1;
    check_eq("rst_state", state_o, 3'd0);
    check_eq("rst_strobes", {imem_req_o, ir_wr_o, pc_wr_o, pc_en_o, epc_wr_o, addr_err_o}, 6'b0);
    check_eq("rst_next_pc", next_pc_o, 30'hbff);
    check_eq("rst_epc_val", epc_val_o, 30'h0);

    // Basic sequential instruction with a 3-cycle fetch
    reset_i = 1'b1; os_i = 1'b1; pc_i = 30'hbff;
    #1;
    check_eq("idle_hold", state_o, 3'd0);
    tick();
    check_eq("fetch_enter", state_o, 3'd1);
    for (int i = 0; i < 3; i++) begin
      imem_ack_i = (i == 2);
      #1;
      check_eq("fetch_req", imem_req_o, 1'b1);
      check_eq("fetch_ir_wr", ir_wr_o, (i == 2) ? 1'b1 : 1'b0);
      tick();
    end
    imem_ack_i = 1'b0;
    #1;
    check_eq("decode_state", state_o, 3'd2);
    check_eq("decode_strobes", {imem_req_o, ir_wr_o, pc_wr_o}, 3'b0);
    tick();
    check_eq("exec_state", state_o, 3'd3);
    exec_done_i = 1'b1;
    #1;
    check_eq("exec_no_err", addr_err_o, 1'b0);
    tick();
    exec_done_i = 1'b0;
    #1;
    check_eq("upd_state", state_o, 3'd4);
    check_eq("upd_wr_en", {pc_wr_o, pc_en_o, epc_wr_o}, 3'b110);
    check_eq("seq_next_pc", next_pc_o, 30'hc00);
    tick();
    check_eq("back_fetch", state_o, 3'd1);

    // Branch taken / not taken
    pc_i = 30'h100; imm16_i = 16'hfffe; is_br_i = 1'b1; br_taken_i = 1'b1;
    run_to_update();
    check_eq("br_taken_npc", next_pc_o, 30'hff);
    tick();
    br_taken_i = 1'b0;
    run_to_update();
    check_eq("br_ntaken_npc", next_pc_o, 30'h101);
    tick();
    is_br_i = 1'b0;

    // Misaligned jr traps
    pc_i = 30'h200; is_jr_i = 1'b1; rs_val_i = 32'h0000_4002;
    fetch_to_exec();
    exec_done_i = 1'b1;
    #1;
    check_eq("jr_addr_err", addr_err_o, 1'b1);
    tick();
    exec_done_i = 1'b0;
    #1;
    check_eq("trap_state", state_o, 3'd5);
    check_eq("trap_strobes", {pc_wr_o, pc_en_o, epc_wr_o, addr_err_o}, 4'b1110);
    check_eq("trap_next_pc", next_pc_o, 30'h20);
    check_eq("trap_epc_val", epc_val_o, 30'h200);
    tick();
    check_eq("trap_to_fetch", state_o, 3'd1);

    // Aligned jr
    rs_val_i = 32'h0000_4000;
    run_to_update();
    check_eq("jr_state", state_o, 3'd4);
    check_eq("jr_next_pc", next_pc_o, 30'h1000);
    tick();
    is_jr_i = 1'b0;

    // Sequential wrap
    pc_i = 30'h3fffffff;
    run_to_update();
    check_eq("wrap_next_pc", next_pc_o, 30'h0);
    tick();

    // Interrupt during jump, then eret
    pc_i = 30'h3ffffff0; is_j_i = 1'b1; jidx_i = 26'h10; int_req_i = 1'b1; int_en_i = 1'b1;
    run_to_update();
    check_eq("int_next_pc", next_pc_o, 30'h20);
    check_eq("int_epc_wr", epc_wr_o, 1'b1);
    check_eq("int_epc_val", epc_val_o, 30'h3c000010);
    tick();
    int_req_i = 1'b0; is_j_i = 1'b0;
    is_eret_i = 1'b1; epc_i = 30'h3c000010;
    run_to_update();
    check_eq("eret_next_pc", next_pc_o, 30'h3c000010);
    check_eq("eret_no_epc_wr", epc_wr_o, 1'b0);
    tick();
    is_eret_i = 1'b0;

    // Exception raised in DECODE
    imem_ack_i = 1'b1;
    #1;
    tick();
    imem_ack_i = 1'b0; exc_req_i = 1'b1;
    #1;
    tick();
    exc_req_i = 1'b0;
    #1;
    check_eq("dec_exc_trap", state_o, 3'd5);
    check_eq("dec_exc_epc", epc_val_o, 30'h3ffffff0);
    tick();

    // os drop while waiting for ack
    os_i = 1'b0;
    #1;
    check_eq("osdrop_req", imem_req_o, 1'b1);
    tick();
    check_eq("osdrop_idle", state_o, 3'd0);
    check_eq("osdrop_strobes", {imem_req_o, ir_wr_o, pc_wr_o}, 3'b0);
    os_i = 1'b1;
    #1;
    tick();
    check_eq("osback_fetch", {state_o, imem_req_o}, {3'd1, 1'b1});

    // Asynchronous reset in EXEC
    fetch_to_exec();
    check_eq("pre_rst_exec", state_o, 3'd3);
    #2;
    reset_i = 1'b0;
    #1;
    check_eq("async_rst_state", state_o, 3'd0);
    check_eq("async_rst_strobes", {imem_req_o, ir_wr_o, pc_wr_o, epc_wr_o}, 4'b0);
    check_eq("async_rst_npc", next_pc_o, 30'hbff);
    tick();
    reset_i = 1'b1;
    #1;
    tick();
    check_eq("rst_restart", {state_o, imem_req_o}, {3'd1, 1'b1});

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
